stream_source: RTL and testbench
================================

# stream_source

Transmit-side counterpart for the test designs' valid/ready byte streams: it buffers words written by the testbench and drives them out as a valid/ready stream, in a form that connects directly to a DUT's `stream_in_valid`/`stream_in_ready`/`stream_in_data`. It contains a small FIFO, a send state machine with programmable inter-beat gaps, and a beat counter. It lives alongside the other simulator test designs and gives cocotb tests a cycle-exact, backpressure-aware stimulus source.

## Interface
- `DATA_WIDTH`, default 8: stream word width.
- `DEPTH`, default 4: total words held. Must be a power of two, at least 2.
- `GAP_CYCLES`, default 0: forced idle cycles after every accepted beat. Range 0..255.

Ports:
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `load_valid`, input, 1: the testbench offers a word.
- `load_ready`, output, 1: high when a word can be accepted, i.e. `fill_level < DEPTH`.
- `load_data`, input, `DATA_WIDTH`: word to enqueue.
- `enable`, input, 1: permits new beats to start.
- `stream_out_valid`, output, 1: a beat is offered.
- `stream_out_ready`, input, 1: downstream accepts the beat.
- `stream_out_data`, output, `DATA_WIDTH`: beat payload.
- `fill_level`, output, `$clog2(DEPTH)+1`: number of words accepted on the load side and not yet transferred on the stream side.
- `beats_sent`, output, 16: count of completed stream handshakes.
- `checksum`, output, 16: running sum of transferred words (see Configuration).

## Operation
- Load handshake occurs when `load_valid && load_ready` at a clock edge. Stream handshake occurs when `stream_out_valid && stream_out_ready` at a clock edge.
- Words leave in strict FIFO order, with no loss and no duplication.
- `load_ready` comes only from registered state, with no combinational path from any input.
- When a load and a stream handshake happen on the same edge, `fill_level` is unchanged.
- When the FIFO is full, a load is refused even if a stream handshake occurs on that same edge.
- FSM states and transitions:
  - IDLE: `stream_out_valid` = 0. Moves to SEND when `enable && fill_level != 0`.
  - SEND: `stream_out_valid` = 1. `stream_out_data` = head word, held stable until the handshake.
    - Once asserted, valid stays asserted regardless of `enable` until the handshake completes.
    - On handshake: go to GAP if `GAP_CYCLES > 0`.
    - Otherwise stay in SEND if `enable` and another word remains after the pop; else go to IDLE. This gives back-to-back beats at 1 per cycle.
  - GAP: valid = 0 for exactly `GAP_CYCLES` cycles, counted by an 8-bit down-counter. Then move to SEND if `enable && fill_level != 0`, else IDLE.
- `beats_sent` increments on each stream handshake and wraps from 0xFFFF to 0x0000.
- `reset` (also mid-transfer): FIFO flushed and FSM to IDLE. The following outputs take these values in the cycle after the reset edge:
  - `stream_out_valid` = 0
  - `stream_out_data` = 0
  - `fill_level` = 0
  - `load_ready` = 1
  - `beats_sent` = 0
  - `checksum` = 0
  - A beat pending at reset is discarded, not counted.

## Timing
- All outputs are registered.
- Load-to-valid latency: a word loaded at edge k into an empty, enabled, idle block gives `stream_out_valid` = 1 after edge k+1, i.e. 2 cycles.
- Throughput is 1 beat per cycle with `GAP_CYCLES` = 0 and `stream_out_ready` held high.
- With `GAP_CYCLES` = G, the minimum spacing between handshakes is G+1 cycles.
- `enable` deasserted prevents a new valid from rising from the next edge; it never truncates an offered beat.
- `stream_out_ready` may change arbitrarily. Data must remain stable while valid is high and ready is low.

## Configuration
- `STREAM_SOURCE_CHECKSUM_EN` defined: `checksum` accumulates `stream_out_data` on each stream handshake. The word is zero-extended to 16 bits and the sum is taken modulo 2^16.
- Macro undefined: the `checksum` port is still present but tied to 0, and no adder is built.

## Test plan
- Reset, then load 0x11, 0x22, 0x33 with `enable`=1 and ready=1, `GAP_CYCLES`=0:
  - Valid rises 2 cycles after the first load.
  - Beats 0x11, 0x22, 0x33 go out on consecutive cycles.
  - `beats_sent`=3 and `fill_level`=0 afterwards.
- Load 5 words with `DEPTH`=4 and ready=0:
  - `load_ready` drops after the 4th load, and the 5th is held off.
  - `stream_out_data` stays 1st word while ready=0.
  - Releasing ready drains all 5 in order.
- `GAP_CYCLES`=3, 2 words queued, ready=1: the handshakes are exactly 4 cycles apart, with valid low for 3 cycles between them.
- Deassert `enable` while valid=1 and ready=0:
  - Valid stays high until ready=1 completes the beat.
  - No further beat starts until `enable` returns.
- Assert `reset` with 3 words queued and valid high:
  - The next cycle shows valid=0, `fill_level`=0, `beats_sent`=0.
  - After reset, the next loaded word 0xA5 is the first beat out.
- With `STREAM_SOURCE_CHECKSUM_EN` defined, send 0xFF ×257: `checksum` = 0xFFFF after 257 beats, and 0x00FE after a 258th beat of 0xFF (modulo wrap). Undefined: `checksum` stays 0.

Source files
------------

// File: rtl/stream_source_if.sv
// stream_source_if: groups the load-side, stream-side and status signals of
// stream_source. The master modport is the view taken by the source itself;
// the slave modport is the view of whatever drives loads and consumes beats.
interface stream_source_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  enable;
    logic                  stream_out_valid;
    logic                  stream_out_ready;
    logic [DATA_WIDTH-1:0] stream_out_data;
    logic [CNT_W-1:0]      fill_level;
    logic [15:0]           beats_sent;
    logic [15:0]           checksum;

    modport master (
        input  load_valid, load_data, enable, stream_out_ready,
        output load_ready, stream_out_valid, stream_out_data,
               fill_level, beats_sent, checksum
    );

    modport slave (
        output load_valid, load_data, enable, stream_out_ready,
        input  load_ready, stream_out_valid, stream_out_data,
               fill_level, beats_sent, checksum
    );
endinterface

// File: rtl/stream_source.sv
// stream_source: buffers words offered on the load side in a small FIFO and
// plays them out as a valid/ready stream, with an optional forced idle gap
// after every accepted beat and a running beat counter.
// Optional feature: define STREAM_SOURCE_CHECKSUM_EN to build the running
// 16-bit checksum of transferred words; otherwise checksum is tied to 0.
module stream_source #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic           clk,
    input  logic           reset,
    stream_source_if.master bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                r_state, w_state_next;
    logic [7:0]            r_gap_cnt, w_gap_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rd_ptr, r_wr_ptr, w_rd_ptr_inc;
    logic [CNT_W-1:0]      r_count, w_count_next;
    logic                  r_load_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data, w_next_head;
    logic [15:0]           r_beats;
    logic                  w_load, w_pop, w_remain;
    logic                  w_take_head, w_take_next;

    // load_ready is a flop, so a full FIFO refuses loads even while popping
    assign w_load       = bus.load_valid && r_load_ready;
    assign w_pop        = r_valid && bus.stream_out_ready;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    // After a pop, the next head is either already stored or is the word
    // being loaded on this very edge (FIFO held exactly one word).
    assign w_remain    = (r_count > ONE) || w_load;
    assign w_next_head = (r_count > ONE) ? r_mem[w_rd_ptr_inc] : bus.load_data;

    // Occupancy after this edge: a simultaneous load and pop cancel out
    always_comb begin
        w_count_next = r_count;
        case ({w_load, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO pointers, occupancy and registered load_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_load_ready <= 1'b1;
        end else begin
            if (w_load) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_count      <= w_count_next;
            r_load_ready <= (w_count_next != FULL);
        end
    end

    // FIFO storage; contents need no reset since the pointers are flushed
    always_ff @(posedge clk) begin
        if (w_load) r_mem[r_wr_ptr] <= bus.load_data;
    end

    // Send FSM state register and gap down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_next;
        end
    end

    // Send FSM next state; also decides when the output word is reloaded
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap_cnt;
        w_take_head  = 1'b0;
        w_take_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enable && (r_count != '0)) begin
                    w_state_next = S_SEND;
                    w_take_head  = 1'b1;
                end
            end
            S_SEND: begin
                if (w_pop) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_next = S_GAP;
                        w_gap_next   = GAP_LOAD;
                    end else if (bus.enable && w_remain) begin
                        w_take_next  = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    if (bus.enable && (r_count != '0)) begin
                        w_state_next = S_SEND;
                        w_take_head  = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_gap_next = r_gap_cnt - 8'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered valid and payload; payload only changes when a new beat starts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= (w_state_next == S_SEND);
            if (w_take_head)      r_data <= r_mem[r_rd_ptr];
            else if (w_take_next) r_data <= w_next_head;
        end
    end

    // Completed-handshake counter, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (reset)      r_beats <= '0;
        else if (w_pop) r_beats <= r_beats + 16'd1;
    end

`ifdef STREAM_SOURCE_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running modulo-2^16 sum of transferred words, zero-extended
    always_ff @(posedge clk) begin
        if (reset)      r_checksum <= '0;
        else if (w_pop) r_checksum <= r_checksum + 16'(r_data);
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 16'd0;
`endif

    assign bus.load_ready       = r_load_ready;
    assign bus.stream_out_valid = r_valid;
    assign bus.stream_out_data  = r_data;
    assign bus.fill_level       = r_count;
    assign bus.beats_sent       = r_beats;
endmodule

// File: tb/tb_stream_source.sv
// tb_stream_source: drives two stream_source instances (no gap, and a
// 3-cycle gap) with shared load/enable stimulus and compares every output,
// every cycle, against a queue-and-timer reference model of the stream rules.
module tb_stream_source;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int GAP1  = 3;

    logic       clk = 1'b0;
    logic       rst, lv, en, rdy0, rdy1;
    logic [7:0] ld;

    always #5 clk = ~clk;

    stream_source_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
    stream_source_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

    assign bus0.load_valid       = lv;
    assign bus0.load_data        = ld;
    assign bus0.enable           = en;
    assign bus0.stream_out_ready = rdy0;
    assign bus1.load_valid       = lv;
    assign bus1.load_data        = ld;
    assign bus1.enable           = en;
    assign bus1.stream_out_ready = rdy1;

    stream_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    stream_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP1)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, one slot per instance
    logic [7:0] m_words [2][DEPTH];
    int         m_head  [2];
    int         m_cnt   [2];
    int         m_wait  [2];
    int         m_beats [2];
    int         m_sum   [2];
    bit         m_off   [2];
    logic [7:0] m_data  [2];
    bit         m_ld_fire [2];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock edge of the stream rules: FIFO order, gap timer, enable gating
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit rdy;
            int g;
            int old_cnt;
            bit load;
            bit pop;
            rdy = (d == 0) ? rdy0 : rdy1;
            g   = (d == 0) ? 0 : GAP1;
            m_ld_fire[d] = 1'b0;
            if (rst) begin
                m_cnt[d] = 0; m_head[d] = 0; m_off[d] = 1'b0; m_data[d] = '0;
                m_wait[d] = 0; m_beats[d] = 0; m_sum[d] = 0;
            end else begin
                old_cnt = m_cnt[d];
                load = lv && (old_cnt < DEPTH);
                pop  = m_off[d] && rdy;
                m_ld_fire[d] = load;
                if (load) m_words[d][(m_head[d] + old_cnt) % DEPTH] = ld;
                if (pop) begin
                    m_beats[d] = (m_beats[d] + 1) % 65536;
                    m_sum[d]   = (m_sum[d] + int'(m_data[d])) % 65536;
                    m_head[d]  = (m_head[d] + 1) % DEPTH;
                end
                m_cnt[d] = old_cnt + int'(load) - int'(pop);
                if (pop) begin
                    if (g > 0) begin
                        m_off[d]  = 1'b0;
                        m_wait[d] = g;
                    end else if (en && m_cnt[d] > 0) begin
                        m_data[d] = m_words[d][m_head[d]];
                    end else begin
                        m_off[d] = 1'b0;
                    end
                end else if (!m_off[d]) begin
                    if (m_wait[d] > 1) begin
                        m_wait[d]--;
                    end else begin
                        m_wait[d] = 0;
                        if (en && old_cnt > 0) begin
                            m_off[d]  = 1'b1;
                            m_data[d] = m_words[d][m_head[d]];
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic v, input logic [7:0] dat,
                             input logic [2:0] fl, input logic lr,
                             input logic [15:0] bs, input logic [15:0] cs);
        string p;
        logic [15:0] exp_cs;
        p = (d == 0) ? "g0" : "g3";
`ifdef STREAM_SOURCE_CHECKSUM_EN
        exp_cs = 16'(m_sum[d]);
`else
        exp_cs = 16'd0;
`endif
        check_eq({p, "_valid"},      32'(v),  32'(m_off[d]));
        check_eq({p, "_data"},       32'(dat), 32'(m_data[d]));
        check_eq({p, "_fill_level"}, 32'(fl), 32'(m_cnt[d]));
        check_eq({p, "_load_ready"}, 32'(lr), 32'(m_cnt[d] < DEPTH));
        check_eq({p, "_beats_sent"}, 32'(bs), 32'(m_beats[d]));
        check_eq({p, "_checksum"},   32'(cs), 32'(exp_cs));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_dut(0, bus0.stream_out_valid, bus0.stream_out_data, bus0.fill_level,
                  bus0.load_ready, bus0.beats_sent, bus0.checksum);
        check_dut(1, bus1.stream_out_valid, bus1.stream_out_data, bus1.fill_level,
                  bus1.load_ready, bus1.beats_sent, bus1.checksum);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cs257;
        logic [15:0] cs258;
        int          loads;
        int          tries;
        bit          done257;
`ifdef STREAM_SOURCE_CHECKSUM_EN
        cs257 = 16'hFFFF;
        cs258 = 16'h00FE;
`else
        cs257 = 16'h0000;
        cs258 = 16'h0000;
`endif
        rst = 1'b1; lv = 1'b0; ld = '0; en = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;

        // three back-to-back words, everything ready
        lv = 1'b1;
        ld = 8'h11; cycle();
        ld = 8'h22; cycle();
        ld = 8'h33; cycle();
        lv = 1'b0;
        repeat (16) cycle();

        // fill past depth with ready low, then release ready
        rdy0 = 1'b0; rdy1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lv = 1'b1; ld = 8'(8'h40 + i);
            tries = 0;
            do begin cycle(); tries++; end while (!m_ld_fire[0] && tries < 10);
        end
        ld = 8'h44;
        repeat (4) cycle();
        rdy0 = 1'b1; rdy1 = 1'b1;
        tries = 0;
        do begin cycle(); tries++; end while (!m_ld_fire[0] && tries < 10);
        lv = 1'b0;
        repeat (30) cycle();

        // drop enable while a beat is stalled
        rdy0 = 1'b0; rdy1 = 1'b0;
        lv = 1'b1;
        ld = 8'h51; cycle();
        ld = 8'h52; cycle();
        lv = 1'b0;
        repeat (3) cycle();
        en = 1'b0;
        repeat (3) cycle();
        rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (8) cycle();
        en = 1'b1;
        repeat (15) cycle();

        // reset with words queued and a beat offered
        rdy0 = 1'b0; rdy1 = 1'b0;
        lv = 1'b1;
        ld = 8'h61; cycle();
        ld = 8'h62; cycle();
        ld = 8'h63; cycle();
        lv = 1'b0;
        repeat (2) cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        lv = 1'b1; ld = 8'hA5; cycle();
        lv = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (10) cycle();

        // 258 beats of 0xFF for the checksum wrap
        rst = 1'b1; cycle();
        rst = 1'b0;
        lv = 1'b1; ld = 8'hFF;
        loads = 0; tries = 0; done257 = 1'b0;
        while (m_beats[0] < 258 && tries < 2000) begin
            cycle();
            tries++;
            if (m_ld_fire[0]) loads++;
            if (loads >= 258) lv = 1'b0;
            if (m_beats[0] == 257 && !done257) begin
                done257 = 1'b1;
                check_eq("cksum_257", 32'(bus0.checksum), 32'(cs257));
            end
        end
        lv = 1'b0;
        check_eq("cksum_258_beats", 32'(bus0.beats_sent), 32'd258);
        check_eq("cksum_258", 32'(bus0.checksum), 32'(cs258));
        repeat (40) cycle();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            lv   = ($urandom_range(0, 2) != 0);
            ld   = 8'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            rdy0 = ($urandom_range(0, 3) != 0);
            rdy1 = ($urandom_range(0, 1) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
